clk_div_checker: RTL and testbench
==================================

Name: clk_div_checker

Overview:
- Receive-side monitor for the T-flop divider chain.
- Samples a divided clock (`div_clk`, nominally `clk_in`/EXP_RATIO) in the `clk_in` domain and measures its period and high time in `clk_in` cycles.
- Checks each period against the expected ratio, declares lock after consecutive good periods, and reports errors and stalls.
- Sits beside any divider stage as a built-in self-check; drives status only, never the clock tree.

Parameters:
- EXP_RATIO, 8, expected division ratio; even, ≥4.
- TOL, 0, allowed ± deviation in `clk_in` cycles for period and high time.
- LOCK_CNT, 4, consecutive good periods required to assert `locked`.
- CNT_W, 8, width of measurement counters; must hold 2*EXP_RATIO+1.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk_in, input, 1, reference clock; sole clock of the block.
- rst, input, 1, asynchronous, active-high reset.
- div_clk, input, 1, divided clock under test; treated as asynchronous data.
- clr_err, input, 1, synchronous pulse; clears `err_cnt`.
- period, output, CNT_W, last measured rising-to-rising period.
- high_time, output, CNT_W, last measured high phase.
- meas_valid, output, 1, one-cycle pulse when `period`/`high_time` update.
- locked, output, 1, LOCK_CNT consecutive good periods seen.
- err, output, 1, one-cycle pulse on a bad period or a stall.
- stall, output, 1, level; no `div_clk` rising edge within 2*EXP_RATIO cycles.
- err_cnt, output, ERR_W, saturating count of `err` pulses.

Behaviour:
Reset:
- All outputs 0; synchroniser flops 0; FSM in IDLE.
- Reset has immediate effect mid-measurement, and the partial period is discarded.

Front end:
- 2-flop synchroniser `s1`→`s2`, plus delay flop `s3`.
- `rise = s2 & ~s3`, `fall = ~s2 & s3`.
- Input-to-`rise` latency is 2–3 `clk_in` cycles. It is constant for a source derived from `clk_in`, so the measurement is exact.

Counters:
- `pcnt`: loads 1 on `rise`, otherwise increments, saturating at all-ones.
- `hcnt`: loads 1 on `rise`, increments while `s2`=1, freezes while `s2`=0.
- On `fall`, the high-time snapshot is latched: `high_snap = hcnt`.

FSM states: IDLE, MEAS, LOCK.
- IDLE: waits for the first `rise`, then goes to MEAS. No `meas_valid` is produced for the first edge.
- MEAS/LOCK on `rise`:
  - `period <= pcnt`, `high_time <= high_snap`, `meas_valid` pulses the next cycle.
  - Good means |`pcnt` − EXP_RATIO| ≤ TOL AND |`high_snap` − EXP_RATIO/2| ≤ TOL.
  - Good: `good_cnt` increments, saturating at LOCK_CNT. When it reaches LOCK_CNT, the FSM goes to LOCK and `locked`=1.
  - Bad: `err` pulses, `good_cnt`=0, FSM goes to MEAS, `locked`=0 in the same cycle as `err`.
- Stall: `pcnt` == 2*EXP_RATIO with no `rise` in MEAS/LOCK:
  - `err` pulses once, `stall`=1, `locked`=0, `good_cnt`=0, FSM goes to IDLE.
  - `stall` clears on the next `rise`. That `rise` is treated as a first edge, so no measurement is made.
- IDLE never times out.

Error counter and simultaneous events:
- `err_cnt` increments on `err` and saturates at 2^ERR_W−1.
- `clr_err` and `err` in the same cycle: the result is 1 (clear, then count).
- `rise` and stall timeout in the same cycle: `rise` wins and is measured normally (`pcnt` = 2*EXP_RATIO → bad unless within TOL).
- `div_clk` stuck high: `hcnt` keeps counting but `pcnt` hits stall first.

Decomposition:
- Package `clk_chk_pkg`:
  - FSM state enum {IDLE, MEAS, LOCK}, 2 bits.
  - Helper constant for the stall limit (2*EXP_RATIO).
- Sub-module `sync_edge_det` holds the synchroniser and `rise`/`fall` generation.
- Counters and FSM stay in `clk_div_checker`.

Test Plan:
- DivideBy8 output driven on `div_clk`, defaults, `rst` released at 50 ns → first `meas_valid` shows `period`=8, `high_time`=4; `locked` rises on the 4th good measurement; `err_cnt`=0.
- Locked, then feed one divide-by-6 period → `err` pulse, `period`=6, `locked` drops that cycle, `err_cnt`=1; relock after 4 more good ÷8 periods.
- Locked, then hold `div_clk` low → `err` plus `stall`=1 exactly 16 cycles after the last `rise`, FSM to IDLE; resume ÷8 → `stall` clears on the first `rise` and `locked` after 5 rises.
- Duty error: period 8 with high time 3, TOL=0 → `err`, `high_time`=3; same stimulus with TOL=1 → no `err`.
- Assert `rst` mid-period while locked → all outputs 0 immediately; after release, behaviour is identical to the first scenario.
- Force 300 bad periods with ERR_W=8 → `err_cnt` saturates at 255; `clr_err` concurrent with an `err` → `err_cnt`=1.

Source files
------------

// File: rtl/clk_chk_pkg.sv
// Shared types and helpers for the divided-clock checker.
// Holds the FSM state encoding and tolerance arithmetic.
package clk_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        LOCK = 2'd2
    } state_t;

    function automatic int stall_limit(input int exp_ratio);
        return 2 * exp_ratio;
    endfunction

    function automatic logic in_tol(input int val, input int target,
                                    input int tol);
        int diff;
        diff = val - target;
        if (diff < 0) diff = -diff;
        return (diff <= tol);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level plus a delay flop
// that yields single-cycle rise/fall strobes in the local domain.
module sync_edge_det (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/clk_div_checker.sv
// Measures period and high time of a divided clock in clk_in cycles,
// tracks lock against the expected ratio and flags errors and stalls.
module clk_div_checker
    import clk_chk_pkg::*;
#(
    parameter int EXP_RATIO = 8,
    parameter int TOL       = 0,
    parameter int LOCK_CNT  = 4,
    parameter int CNT_W     = 8,
    parameter int ERR_W     = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             div_clk,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             err,
    output logic             stall,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);
    localparam logic [CNT_W-1:0] STALL_V = CNT_W'(stall_limit(EXP_RATIO));

    logic s2, rise, fall;

    sync_edge_det u_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .d      (div_clk),
        .level  (s2),
        .rise   (rise),
        .fall   (fall)
    );

    state_t state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_snap_q, high_snap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic [GW-1:0]    good_cnt_q, good_cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic meas_valid_q, meas_valid_d;
    logic locked_q, locked_d;
    logic err_q, err_d;
    logic stall_q, stall_d;
    logic good;

    always_comb begin
        pcnt_d      = pcnt_q;
        hcnt_d      = hcnt_q;
        high_snap_d = high_snap_q;
        if (rise) begin
            pcnt_d = CNT_W'(1);
            hcnt_d = CNT_W'(1);
        end else begin
            if (pcnt_q != '1) pcnt_d = pcnt_q + CNT_W'(1);
            if (s2 && hcnt_q != '1) hcnt_d = hcnt_q + CNT_W'(1);
        end
        if (fall) high_snap_d = hcnt_q;
    end

    always_comb begin
        good = in_tol(int'(pcnt_q), EXP_RATIO, TOL) &&
               in_tol(int'(high_snap_q), EXP_RATIO / 2, TOL);
    end

    // A rise always beats the stall timeout in the same cycle.
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        good_cnt_d   = good_cnt_q;
        meas_valid_d = 1'b0;
        err_d        = 1'b0;
        locked_d     = locked_q;
        stall_d      = stall_q;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEAS;
                    stall_d = 1'b0;
                end
            end
            MEAS, LOCK: begin
                if (rise) begin
                    period_d     = pcnt_q;
                    high_time_d  = high_snap_q;
                    meas_valid_d = 1'b1;
                    if (good) begin
                        if (good_cnt_q != LOCK_V) begin
                            good_cnt_d = good_cnt_q + GW'(1);
                        end
                        if (good_cnt_d == LOCK_V) begin
                            state_d  = LOCK;
                            locked_d = 1'b1;
                        end
                    end else begin
                        err_d      = 1'b1;
                        good_cnt_d = '0;
                        state_d    = MEAS;
                        locked_d   = 1'b0;
                    end
                end else if (pcnt_q == STALL_V) begin
                    err_d      = 1'b1;
                    stall_d    = 1'b1;
                    locked_d   = 1'b0;
                    good_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear first, then count, so a clear racing an error leaves 1.
    always_comb begin
        err_cnt_d = clr_err ? '0 : err_cnt_q;
        if (err_q && err_cnt_d != '1) err_cnt_d = err_cnt_d + ERR_W'(1);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pcnt_q       <= '0;
            hcnt_q       <= '0;
            high_snap_q  <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            good_cnt_q   <= '0;
            err_cnt_q    <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            hcnt_q       <= hcnt_d;
            high_snap_q  <= high_snap_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            good_cnt_q   <= good_cnt_d;
            err_cnt_q    <= err_cnt_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            stall_q      <= stall_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign stall      = stall_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_clk_div_checker.sv
// Directed bench: two checkers (TOL=0 and TOL=1) watch the same
// bench-generated divided clock.
module tb_clk_div_checker;

    logic clk_in = 1'b0;
    logic rst = 1'b1;
    logic div_clk = 1'b0;
    logic clr_err = 1'b0;

    logic [7:0] period, high_time, err_cnt;
    logic meas_valid, locked, err, stall;
    logic [7:0] period_b, high_time_b, err_cnt_b;
    logic meas_valid_b, locked_b, err_b, stall_b;

    clk_div_checker #(.TOL(0)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .div_clk    (div_clk),
        .clr_err    (clr_err),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .err        (err),
        .stall      (stall),
        .err_cnt    (err_cnt)
    );

    clk_div_checker #(.TOL(1)) dut_b (
        .clk_in     (clk_in),
        .rst        (rst),
        .div_clk    (div_clk),
        .clr_err    (clr_err),
        .period     (period_b),
        .high_time  (high_time_b),
        .meas_valid (meas_valid_b),
        .locked     (locked_b),
        .err        (err_b),
        .stall      (stall_b),
        .err_cnt    (err_cnt_b)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    int n_meas = 0;
    int n_err = 0;
    int n_err_b = 0;
    int last_meas_cyc = 0;
    int err_cyc = 0;
    int last_p = 0;
    int last_h = 0;
    int last_h_b = 0;
    logic err_locked = 1'b1;

    always @(negedge clk_in) begin
        cyc = cyc + 1;
        if (meas_valid === 1'b1) begin
            n_meas = n_meas + 1;
            last_p = int'(period);
            last_h = int'(high_time);
            last_meas_cyc = cyc;
        end
        if (meas_valid_b === 1'b1) last_h_b = int'(high_time_b);
        if (err === 1'b1) begin
            n_err = n_err + 1;
            err_cyc = cyc;
            err_locked = locked;
        end
        if (err_b === 1'b1) n_err_b = n_err_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic gen(input int hi, input int lo);
        @(posedge clk_in);
        #1 div_clk = 1'b1;
        repeat (hi) @(posedge clk_in);
        #1 div_clk = 1'b0;
        repeat (lo - 1) @(posedge clk_in);
    endtask

    task automatic settle();
        @(negedge clk_in);
        #1;
    endtask

    int m0, m1, mb;
    int k;

    initial begin
        #20;
        check("rst_period", 32'(period), 0);
        check("rst_high", 32'(high_time), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_meas_valid", 32'(meas_valid), 0);
        #30 rst = 1'b0;

        // Nominal divide-by-8
        repeat (2) gen(4, 4);
        settle();
        check("s1_nmeas", 32'(n_meas), 1);
        check("s1_period", 32'(last_p), 8);
        check("s1_high", 32'(last_h), 4);
        repeat (2) gen(4, 4);
        settle();
        check("s1_not_locked_3", 32'(locked), 0);
        gen(4, 4);
        settle();
        check("s1_locked_4", 32'(locked), 1);
        check("s1_nmeas_4", 32'(n_meas), 4);
        check("s1_err_cnt", 32'(err_cnt), 0);

        // One divide-by-6 period while locked
        m0 = n_err;
        gen(3, 3);
        gen(4, 4);
        settle();
        check("s2_err_pulses", 32'(n_err - m0), 1);
        check("s2_period", 32'(last_p), 6);
        check("s2_locked_at_err", 32'(err_locked), 0);
        check("s2_err_cnt", 32'(err_cnt), 1);
        repeat (3) gen(4, 4);
        settle();
        check("s2_not_relocked", 32'(locked), 0);
        gen(4, 4);
        settle();
        check("s2_relocked", 32'(locked), 1);

        // Stall: hold div_clk low
        m0 = n_err;
        repeat (30) @(posedge clk_in);
        settle();
        check("s3_stall", 32'(stall), 1);
        check("s3_err_pulses", 32'(n_err - m0), 1);
        check("s3_stall_delay", 32'(err_cyc - last_meas_cyc), 16);
        check("s3_locked", 32'(locked), 0);
        check("s3_err_cnt", 32'(err_cnt), 2);
        repeat (40) @(posedge clk_in);
        settle();
        check("s3_idle_no_timeout", 32'(n_err - m0), 1);
        m1 = n_meas;
        gen(4, 4);
        settle();
        check("s3_stall_cleared", 32'(stall), 0);
        check("s3_no_meas_first", 32'(n_meas - m1), 0);
        repeat (3) gen(4, 4);
        settle();
        check("s3_not_locked_4", 32'(locked), 0);
        gen(4, 4);
        settle();
        check("s3_locked_5", 32'(locked), 1);
        check("s3_nmeas", 32'(n_meas - m1), 4);

        // Duty error: high 3, low 5
        m0 = n_err;
        mb = n_err_b;
        gen(3, 5);
        gen(4, 4);
        settle();
        check("s4_err_tol0", 32'(n_err - m0), 1);
        check("s4_high_tol0", 32'(last_h), 3);
        check("s4_period_tol0", 32'(last_p), 8);
        check("s4_err_tol1", 32'(n_err_b - mb), 0);
        check("s4_high_tol1", 32'(last_h_b), 3);
        check("s4_locked_tol1", 32'(locked_b), 1);

        // Reset mid-period while locked
        repeat (4) gen(4, 4);
        settle();
        check("s5_pre_locked", 32'(locked), 1);
        check("s5_pre_err_cnt", 32'(err_cnt), 3);
        @(posedge clk_in);
        #1 div_clk = 1'b1;
        repeat (2) @(posedge clk_in);
        #3 rst = 1'b1;
        #1;
        check("s5_period", 32'(period), 0);
        check("s5_high", 32'(high_time), 0);
        check("s5_locked", 32'(locked), 0);
        check("s5_err_cnt", 32'(err_cnt), 0);
        check("s5_stall", 32'(stall), 0);
        check("s5_meas_valid", 32'(meas_valid), 0);
        div_clk = 1'b0;
        repeat (3) @(posedge clk_in);
        #2 rst = 1'b0;
        m1 = n_meas;
        repeat (2) gen(4, 4);
        settle();
        check("s5_nmeas", 32'(n_meas - m1), 1);
        check("s5_re_period", 32'(last_p), 8);
        check("s5_re_high", 32'(last_h), 4);
        repeat (2) gen(4, 4);
        settle();
        check("s5_not_locked_3", 32'(locked), 0);
        gen(4, 4);
        settle();
        check("s5_locked_4", 32'(locked), 1);

        // Error counter saturation and clear racing an error
        m0 = n_err;
        repeat (301) gen(3, 3);
        settle();
        check("s6_err_pulses", 32'(n_err - m0), 300);
        check("s6_err_cnt_sat", 32'(err_cnt), 255);
        @(posedge clk_in);
        #1 div_clk = 1'b1;
        k = 0;
        while (err !== 1'b1 && k < 10) begin
            @(negedge clk_in);
            k++;
        end
        check("s6_err_seen", 32'(err), 1);
        clr_err = 1'b1;
        @(posedge clk_in);
        #1 clr_err = 1'b0;
        div_clk = 1'b0;
        repeat (2) @(posedge clk_in);
        settle();
        check("s6_clr_with_err", 32'(err_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
